character_ring_buffer: RTL and testbench
========================================

Name: character_ring_buffer

Overview:
- Parametrised circular FIFO for keyboard character data, the next generation of the fixed 32x64 character register file.
- The keyboard scan/decode logic pushes characters at the tail; the consumer (CPU-side peripheral read logic) pops from the head.
- A second, random-access peek port reads any queued entry by offset from the head without removing it.
- Adds occupancy tracking, full/empty flags and sticky overflow/underflow error flags.

Parameters:
WIDTH, 64, bits per character entry
DEPTH, 32, number of entries; must be a power of two and at least 2
ADDR_BITS, 5, log2(DEPTH); width of the pointers and of peek_index

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
clear  input  1  synchronous flush of pointers, count and error flags
push  input  1  write data_in at the tail this cycle
data_in  input  WIDTH  character to enqueue
pop  input  1  remove the head entry this cycle
data_out  output  WIDTH  head entry (show-ahead); 0 when empty
peek_index  input  ADDR_BITS  offset from head for the peek port
peek_data  output  WIDTH  entry at head+peek_index; 0 when peek_valid=0
peek_valid  output  1  peek_index < count
count  output  ADDR_BITS+1  number of entries held, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow  output  1  sticky: a push was dropped
underflow  output  1  sticky: a pop was ignored

Behaviour:
- One clock domain. Reset is asynchronous and active-high; all state updates on the rising edge of clock.
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - head, tail and count = 0; overflow and underflow = 0; all storage entries = 0.
  - Outputs after reset: empty=1, full=0, data_out=0, peek_valid=0, peek_data=0.
- Storage: DEPTH x WIDTH registers. Pointers are ADDR_BITS wide and wrap modulo DEPTH (DEPTH-1 -> 0). count is tracked separately, so full and empty are never ambiguous.
- Read paths are combinational from registered state, with zero latency:
  - data_out = mem[head] when !empty, else 0.
  - peek_data = mem[(head+peek_index) mod DEPTH] when peek_valid, else 0.
- Priority per cycle is clear > push/pop.
- clear=1:
  - head, tail and count = 0; overflow and underflow = 0.
  - push and pop that cycle are ignored and do not set any flag.
  - Storage is not erased.
- Push accept: push=1 and (!full or pop=1). Writes mem[tail]<=data_in, tail<=tail+1.
- Pop accept: pop=1 and !empty. head<=head+1.
- count update: +1 on push-only, -1 on pop-only, unchanged when both are accepted.
- Full with push=1 and pop=1: both are accepted. The head entry leaves and the new entry is written at tail. count stays DEPTH and overflow is not set.
- Full with push=1 and pop=0: data is dropped, overflow<=1, and no pointer or count change.
- Empty with pop=1: the pop is ignored and underflow<=1. A simultaneous push is still accepted, giving count=1.
- Flags are sticky and clear only on reset or clear.
- Wrap-around: after DEPTH accepted pushes the tail returns to 0. Ordering is preserved across the wrap.
- Outputs update in the cycle after the accepting edge; there is no internal pipeline.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, data_out=0, overflow=0, underflow=0. Pulse reset mid-stream after 3 pushes -> all return to those values immediately, without waiting for a clock edge.
- DEPTH=32: push 0x41..0x60 (32 entries) -> full=1, count=32. 33rd push 0xFF -> dropped, overflow=1. Pop 32 times -> data_out sequence 0x41..0x60, then empty=1.
- Push 20 and pop 20, then push 20 more (tail wraps past 31 to 0) -> data popped in push order, count tracks each step, no flags set.
- Pop on empty -> underflow=1, count stays 0. Push 0x55 with pop in the same cycle while empty -> count=1, data_out=0x55.
- Full FIFO with push=0xAA and pop in the same cycle -> count stays 32, overflow=0. The old head leaves, and 0xAA appears as the last entry (peek_index=31).
- After pushes 0x10,0x20,0x30: peek_index=2 -> peek_data=0x30, peek_valid=1; peek_index=3 -> peek_valid=0, peek_data=0. Then clear together with push -> count=0, flags=0, push ignored.

Source files
------------

// File: rtl/character_ring_buffer.sv
// Circular FIFO for keyboard character data with show-ahead head output,
// random-access peek by offset from head, occupancy and sticky error flags.
module character_ring_buffer #(
   parameter int unsigned WIDTH     = 64,
   parameter int unsigned DEPTH     = 32,
   parameter int unsigned ADDR_BITS = 5
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 push,
   input  logic [WIDTH-1:0]     data_in,
   input  logic                 pop,
   output logic [WIDTH-1:0]     data_out,
   input  logic [ADDR_BITS-1:0] peek_index,
   output logic [WIDTH-1:0]     peek_data,
   output logic                 peek_valid,
   output logic [ADDR_BITS:0]   count,
   output logic                 full,
   output logic                 empty,
   output logic                 overflow,
   output logic                 underflow
);

   localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS+1)'(DEPTH);

   logic [WIDTH-1:0]     mem [DEPTH];
   logic [ADDR_BITS-1:0] head;
   logic [ADDR_BITS-1:0] tail;
   logic [ADDR_BITS-1:0] peek_addr;
   logic                 push_ok;
   logic                 pop_ok;

   assign full  = (count == FULL_COUNT);
   assign empty = (count == '0);

   // A push into a full buffer is still taken when a pop frees the head slot.
   always_comb begin
      pop_ok  = pop && !empty;
      push_ok = push && (!full || pop);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clear) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push_ok) begin
            mem[tail] <= data_in;
            tail      <= tail + ADDR_BITS'(1);
         end
         if (pop_ok) begin
            head <= head + ADDR_BITS'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (ADDR_BITS+1)'(1);
            2'b01:   count <= count - (ADDR_BITS+1)'(1);
            default: count <= count;
         endcase
         if (push && !push_ok) begin
            overflow <= 1'b1;
         end
         if (pop && !pop_ok) begin
            underflow <= 1'b1;
         end
      end
   end

   assign peek_addr = head + peek_index;

   always_comb begin
      peek_valid = ({1'b0, peek_index} < count);
      data_out   = empty      ? '0 : mem[head];
      peek_data  = peek_valid ? mem[peek_addr] : '0;
   end

endmodule

// File: tb/tb_character_ring_buffer.sv
// Scoreboard bench for character_ring_buffer: a queue-based reference model
// predicts every post-edge output; a negedge monitor compares against the DUT.
module tb_character_ring_buffer;

   localparam int unsigned WIDTH     = 64;
   localparam int unsigned DEPTH     = 32;
   localparam int unsigned ADDR_BITS = 5;

   typedef struct {
      logic [63:0] dout;
      logic [63:0] pdata;
      logic [5:0]  cnt;
      logic        full;
      logic        empty;
      logic        pvalid;
      logic        ovf;
      logic        unf;
   } exp_t;

   logic                 clock = 1'b0;
   logic                 reset = 1'b0;
   logic                 clear = 1'b0;
   logic                 push  = 1'b0;
   logic                 pop   = 1'b0;
   logic [WIDTH-1:0]     data_in = '0;
   logic [ADDR_BITS-1:0] peek_index = '0;
   logic [WIDTH-1:0]     data_out;
   logic [WIDTH-1:0]     peek_data;
   logic                 peek_valid;
   logic [ADDR_BITS:0]   count;
   logic                 full;
   logic                 empty;
   logic                 overflow;
   logic                 underflow;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   logic [63:0] model_q[$];
   logic        model_ovf = 1'b0;
   logic        model_unf = 1'b0;
   exp_t        sb[$];

   character_ring_buffer #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .ADDR_BITS(ADDR_BITS)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .clear     (clear),
      .push      (push),
      .data_in   (data_in),
      .pop       (pop),
      .data_out  (data_out),
      .peek_index(peek_index),
      .peek_data (peek_data),
      .peek_valid(peek_valid),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow),
      .underflow (underflow)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t predict(input int unsigned pidx);
      exp_t e;
      int unsigned n;
      n        = model_q.size();
      e.cnt    = 6'(n);
      e.full   = (n == DEPTH);
      e.empty  = (n == 0);
      e.dout   = (n > 0) ? model_q[0] : 64'd0;
      e.pvalid = (pidx < n);
      e.pdata  = (pidx < n) ? model_q[pidx] : 64'd0;
      e.ovf    = model_ovf;
      e.unf    = model_unf;
      return e;
   endfunction

   // Reference behaviour: clear wins; a full buffer takes a push only alongside a pop.
   task automatic model_step(input bit clr, input bit ps, input bit pp, input logic [63:0] d);
      bit was_full, was_empty, take_pop, take_push;
      if (clr) begin
         model_q.delete();
         model_ovf = 1'b0;
         model_unf = 1'b0;
         return;
      end
      was_full  = (model_q.size() == DEPTH);
      was_empty = (model_q.size() == 0);
      take_pop  = pp && !was_empty;
      take_push = ps && (!was_full || pp);
      if (ps && !take_push) model_ovf = 1'b1;
      if (pp && !take_pop)  model_unf = 1'b1;
      if (take_pop)  void'(model_q.pop_front());
      if (take_push) model_q.push_back(d);
   endtask

   task automatic cycle(input bit clr, input bit ps, input bit pp, input logic [63:0] d,
                        input int unsigned pidx);
      @(negedge clock);
      #1;
      clear      = clr;
      push       = ps;
      pop        = pp;
      data_in    = d;
      peek_index = ADDR_BITS'(pidx);
      @(posedge clock);
      model_step(clr, ps, pp, d);
      sb.push_back(predict(pidx));
      #1;
      clear = 1'b0;
      push  = 1'b0;
      pop   = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_count"},      64'(count),      64'd0);
      check({tag, "_empty"},      64'(empty),      64'd1);
      check({tag, "_full"},       64'(full),       64'd0);
      check({tag, "_data_out"},   data_out,        64'd0);
      check({tag, "_overflow"},   64'(overflow),   64'd0);
      check({tag, "_underflow"},  64'(underflow),  64'd0);
      check({tag, "_peek_valid"}, 64'(peek_valid), 64'd0);
      check({tag, "_peek_data"},  peek_data,       64'd0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("count",      64'(count),      64'(e.cnt));
            check("full",       64'(full),       64'(e.full));
            check("empty",      64'(empty),      64'(e.empty));
            check("data_out",   data_out,        e.dout);
            check("peek_valid", 64'(peek_valid), 64'(e.pvalid));
            check("peek_data",  peek_data,       e.pdata);
            check("overflow",   64'(overflow),   64'(e.ovf));
            check("underflow",  64'(underflow),  64'(e.unf));
         end
      end
   end

   initial begin : stimulus
      int unsigned p_push, p_pop;
      #1 reset = 1'b1;
      #1 check_reset_state("por");
      repeat (2) @(posedge clock);
      @(negedge clock);
      #1 reset = 1'b0;
      cycle(0, 0, 0, 64'd0, 0);

      // Fill to full, drop one, drain in order.
      for (int i = 0; i < 32; i++) cycle(0, 1, 0, 64'h41 + 64'(i), 31 - i);
      cycle(0, 1, 0, 64'hFF, 31);
      for (int i = 0; i < 32; i++) cycle(0, 0, 1, 64'd0, i);
      cycle(1, 0, 0, 64'd0, 0);

      // Tail wrap-around with ordering preserved.
      for (int i = 0; i < 20; i++) cycle(0, 1, 0, 64'h100 + 64'(i), i);
      for (int i = 0; i < 20; i++) cycle(0, 0, 1, 64'd0, 0);
      for (int i = 0; i < 20; i++) cycle(0, 1, 0, 64'h200 + 64'(i), 19);
      for (int i = 0; i < 20; i++) cycle(0, 0, 1, 64'd0, 1);

      // Underflow, then push+pop on empty.
      cycle(0, 0, 1, 64'd0, 0);
      cycle(0, 1, 1, 64'h55, 0);
      cycle(1, 0, 0, 64'd0, 0);

      // Full with simultaneous push+pop.
      for (int i = 0; i < 32; i++) cycle(0, 1, 0, 64'h300 + 64'(i), 0);
      cycle(0, 1, 1, 64'hAA, 31);
      cycle(0, 0, 0, 64'd0, 30);

      // Peek boundary, then clear beats push.
      cycle(1, 0, 0, 64'd0, 0);
      cycle(0, 1, 0, 64'h10, 0);
      cycle(0, 1, 0, 64'h20, 0);
      cycle(0, 1, 0, 64'h30, 0);
      cycle(0, 0, 0, 64'd0, 2);
      cycle(0, 0, 0, 64'd0, 3);
      cycle(1, 1, 0, 64'h77, 0);
      cycle(0, 0, 0, 64'd0, 0);

      // Randomised traffic, alternating fill-biased and drain-biased phases.
      for (int k = 0; k < 2000; k++) begin
         p_push = ((k / 250) % 2 == 0) ? 70 : 30;
         p_pop  = 100 - p_push;
         cycle(($urandom_range(0, 99) < 1),
               ($urandom_range(0, 99) < p_push),
               ($urandom_range(0, 99) < p_pop),
               {$urandom, $urandom},
               $urandom_range(0, 31));
      end

      // Asynchronous reset mid-stream.
      cycle(1, 0, 0, 64'd0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 64'hC0 + 64'(i), 1);
      @(negedge clock);
      #1 reset = 1'b1;
      #1 check_reset_state("mid_reset");
      #1 reset = 1'b0;
      model_step(1, 0, 0, 64'd0);
      cycle(0, 0, 0, 64'd0, 0);
      cycle(0, 1, 0, 64'h99, 0);

      repeat (3) @(negedge clock);
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
